// File: rtl/aclk_timekeeper.sv
// aclk_timekeeper: BCD HH:MM:SS real-time counter with a programmable HH:MM alarm.
// A prescaler divides clk down to one-second steps. Loads are range-checked
// before they touch the time or alarm registers, and al_match pulses once when
// the time lands on the alarm minute at second 00.
module aclk_timekeeper #(
   parameter int TICKS_PER_SEC = 10
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       LD_time,
   input  logic       LD_alarm,
   input  logic [1:0] H_in1,
   input  logic [3:0] H_in0,
   input  logic [3:0] M_in1,
   input  logic [3:0] M_in0,
   output logic [1:0] H_out1,
   output logic [3:0] H_out0,
   output logic [3:0] M_out1,
   output logic [3:0] M_out0,
   output logic [3:0] S_out1,
   output logic [3:0] S_out0,
   output logic       sec_tick,
   output logic       ld_err,
   output logic       al_match
);

   localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [PW-1:0] LAST_TICK = PW'(TICKS_PER_SEC - 1);

   logic [PW-1:0] presc_q, presc_d;
   logic [1:0]    hour1_q, hour1_d;
   logic [3:0]    hour0_q, hour0_d;
   logic [3:0]    min1_q, min1_d;
   logic [3:0]    min0_q, min0_d;
   logic [3:0]    sec1_q, sec1_d;
   logic [3:0]    sec0_q, sec0_d;
   logic [1:0]    alHour1_q, alHour1_d;
   logic [3:0]    alHour0_q, alHour0_d;
   logic [3:0]    alMin1_q, alMin1_d;
   logic [3:0]    alMin0_q, alMin0_d;
   logic          secTick_q, secTick_d;
   logic          ldErr_q, ldErr_d;
   logic          alMatch_q, alMatch_d;

   logic [5:0]    hourValue;
   logic          inputValid;
   logic          loadTime;
   logic          loadAlarm;
   logic          rollover;

   // Next-state logic: load validation, prescaler, BCD carry chain and alarm compare.
   always_comb begin
      hourValue  = (6'(H_in1) * 6'd10) + 6'(H_in0);
      inputValid = (H_in0 <= 4'd9) && (M_in1 <= 4'd5) && (M_in0 <= 4'd9) && (hourValue <= 6'd23);
      loadTime   = LD_time && inputValid;
      loadAlarm  = LD_alarm && inputValid;
      rollover   = (presc_q == LAST_TICK);

      presc_d   = presc_q;
      hour1_d   = hour1_q;
      hour0_d   = hour0_q;
      min1_d    = min1_q;
      min0_d    = min0_q;
      sec1_d    = sec1_q;
      sec0_d    = sec0_q;
      alHour1_d = alHour1_q;
      alHour0_d = alHour0_q;
      alMin1_d  = alMin1_q;
      alMin0_d  = alMin0_q;
      secTick_d = 1'b0;
      ldErr_d   = (LD_time || LD_alarm) && !inputValid;
      alMatch_d = 1'b0;

      if (loadTime) begin
         hour1_d = H_in1;
         hour0_d = H_in0;
         min1_d  = M_in1;
         min0_d  = M_in0;
         sec1_d  = 4'd0;
         sec0_d  = 4'd0;
         presc_d = '0;
      end else if (rollover) begin
         presc_d   = '0;
         secTick_d = 1'b1;
         if (sec0_q == 4'd9) begin
            sec0_d = 4'd0;
            if (sec1_q == 4'd5) begin
               sec1_d = 4'd0;
               if (min0_q == 4'd9) begin
                  min0_d = 4'd0;
                  if (min1_q == 4'd5) begin
                     min1_d = 4'd0;
                     if ((hour1_q == 2'd2) && (hour0_q == 4'd3)) begin
                        hour1_d = 2'd0;
                        hour0_d = 4'd0;
                     end else if (hour0_q == 4'd9) begin
                        hour0_d = 4'd0;
                        hour1_d = hour1_q + 2'd1;
                     end else begin
                        hour0_d = hour0_q + 4'd1;
                     end
                  end else begin
                     min1_d = min1_q + 4'd1;
                  end
               end else begin
                  min0_d = min0_q + 4'd1;
               end
            end else begin
               sec1_d = sec1_q + 4'd1;
            end
         end else begin
            sec0_d = sec0_q + 4'd1;
         end
      end else begin
         presc_d = presc_q + 1'b1;
      end

      if (loadAlarm) begin
         alHour1_d = H_in1;
         alHour0_d = H_in0;
         alMin1_d  = M_in1;
         alMin0_d  = M_in0;
      end

      alMatch_d = (loadTime || rollover)
                  && (hour1_d == alHour1_d) && (hour0_d == alHour0_d)
                  && (min1_d == alMin1_d) && (min0_d == alMin0_d)
                  && (sec1_d == 4'd0) && (sec0_d == 4'd0);
   end

   // State registers; reset clears time, alarm, prescaler and all pulses.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         presc_q   <= '0;
         hour1_q   <= 2'd0;
         hour0_q   <= 4'd0;
         min1_q    <= 4'd0;
         min0_q    <= 4'd0;
         sec1_q    <= 4'd0;
         sec0_q    <= 4'd0;
         alHour1_q <= 2'd0;
         alHour0_q <= 4'd0;
         alMin1_q  <= 4'd0;
         alMin0_q  <= 4'd0;
         secTick_q <= 1'b0;
         ldErr_q   <= 1'b0;
         alMatch_q <= 1'b0;
      end else begin
         presc_q   <= presc_d;
         hour1_q   <= hour1_d;
         hour0_q   <= hour0_d;
         min1_q    <= min1_d;
         min0_q    <= min0_d;
         sec1_q    <= sec1_d;
         sec0_q    <= sec0_d;
         alHour1_q <= alHour1_d;
         alHour0_q <= alHour0_d;
         alMin1_q  <= alMin1_d;
         alMin0_q  <= alMin0_d;
         secTick_q <= secTick_d;
         ldErr_q   <= ldErr_d;
         alMatch_q <= alMatch_d;
      end
   end

   assign H_out1   = hour1_q;
   assign H_out0   = hour0_q;
   assign M_out1   = min1_q;
   assign M_out0   = min0_q;
   assign S_out1   = sec1_q;
   assign S_out0   = sec0_q;
   assign sec_tick = secTick_q;
   assign ld_err   = ldErr_q;
   assign al_match = alMatch_q;

endmodule

// File: tb/tb_aclk_timekeeper.sv
// tb_aclk_timekeeper: drives directed and random loads into aclk_timekeeper and
// compares every cycle against a seconds-of-day reference model.
module tb_aclk_timekeeper;

   localparam int TPS = 10;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       LD_time = 1'b0;
   logic       LD_alarm = 1'b0;
   logic [1:0] H_in1 = '0;
   logic [3:0] H_in0 = '0;
   logic [3:0] M_in1 = '0;
   logic [3:0] M_in0 = '0;
   logic [1:0] H_out1;
   logic [3:0] H_out0;
   logic [3:0] M_out1;
   logic [3:0] M_out0;
   logic [3:0] S_out1;
   logic [3:0] S_out0;
   logic       sec_tick;
   logic       ld_err;
   logic       al_match;

   int testCount = 0;
   int failCount = 0;

   // Reference state: time as seconds of day, alarm as minutes of day.
   int mTime = 0;
   int mAlarm = 0;
   int mPresc = 0;
   bit mTick = 0;
   bit mErr = 0;
   bit mMatch = 0;

   int tickSeen = 0;
   int errSeen = 0;
   int matchSeen = 0;

   aclk_timekeeper #(.TICKS_PER_SEC(TPS)) dut (
      .clk(clk), .rst_n(rst_n), .LD_time(LD_time), .LD_alarm(LD_alarm),
      .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
      .H_out1(H_out1), .H_out0(H_out0), .M_out1(M_out1), .M_out0(M_out0),
      .S_out1(S_out1), .S_out0(S_out0),
      .sec_tick(sec_tick), .ld_err(ld_err), .al_match(al_match)
   );

   // 10-unit clock period.
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   function automatic logic [21:0] timeDigits(input int s);
      int hh, mm, ss;
      hh = s / 3600;
      mm = (s / 60) % 60;
      ss = s % 60;
      return {2'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
   endfunction

   // Advance the reference by one clock edge using the inputs seen at that edge.
   task automatic modelEdge();
      int h, m;
      bit valid, changed;
      if (!rst_n) begin
         mTime = 0; mAlarm = 0; mPresc = 0;
         mTick = 0; mErr = 0; mMatch = 0;
         return;
      end
      h = int'(H_in1) * 10 + int'(H_in0);
      m = int'(M_in1) * 10 + int'(M_in0);
      valid = (H_in0 <= 9) && (M_in1 <= 5) && (M_in0 <= 9) && (h <= 23);
      mErr = (LD_time || LD_alarm) && !valid;
      mTick = 0;
      changed = 0;
      if (LD_time && valid) begin
         mTime = h * 3600 + m * 60;
         mPresc = 0;
         changed = 1;
      end else if (mPresc == TPS - 1) begin
         mPresc = 0;
         mTime = (mTime + 1) % 86400;
         mTick = 1;
         changed = 1;
      end else begin
         mPresc++;
      end
      if (LD_alarm && valid) mAlarm = h * 60 + m;
      mMatch = changed && (mTime == mAlarm * 60);
   endtask

   task automatic runCycle();
      @(posedge clk);
      modelEdge();
      #1;
      checkOutput("time", 32'({H_out1, H_out0, M_out1, M_out0, S_out1, S_out0}), 32'(timeDigits(mTime)));
      checkOutput("sec_tick", 32'(sec_tick), 32'(mTick));
      checkOutput("ld_err", 32'(ld_err), 32'(mErr));
      checkOutput("al_match", 32'(al_match), 32'(mMatch));
      tickSeen += int'(sec_tick);
      errSeen += int'(ld_err);
      matchSeen += int'(al_match);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) runCycle();
   endtask

   task automatic clearCounts();
      tickSeen = 0;
      errSeen = 0;
      matchSeen = 0;
   endtask

   task automatic applyStimulus(input bit rst, input bit ldT, input bit ldA,
                                input int h1, input int h0, input int m1, input int m0, input int n);
      rst_n = ~rst;
      LD_time = ldT;
      LD_alarm = ldA;
      H_in1 = 2'(h1);
      H_in0 = 4'(h0);
      M_in1 = 4'(m1);
      M_in0 = 4'(m0);
      idle(n);
      rst_n = 1'b1;
      LD_time = 1'b0;
      LD_alarm = 1'b0;
   endtask

   initial begin
      // Reset, then free run: ticks after edges 10 and 20.
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 2);
      clearCounts();
      idle(25);
      checkOutput("free_run_ticks", 32'(tickSeen), 32'd2);
      checkOutput("free_run_s0", 32'(S_out0), 32'd2);

      // Midnight wrap from 23:59 over 600 cycles.
      applyStimulus(0, 1, 0, 2, 3, 5, 9, 1);
      clearCounts();
      idle(600);
      checkOutput("wrap_time", 32'({H_out1, H_out0, M_out1, M_out0, S_out1, S_out0}), 32'd0);
      checkOutput("wrap_ticks", 32'(tickSeen), 32'd60);

      // Alarm 00:02, time 00:01: exactly one match over the next minute and change.
      applyStimulus(0, 0, 1, 0, 0, 0, 2, 1);
      applyStimulus(0, 1, 0, 0, 0, 0, 1, 1);
      clearCounts();
      idle(620);
      checkOutput("alarm_match_count", 32'(matchSeen), 32'd1);

      // Rejected loads: 24:30, minute tens 6, alarm hour units 0xA, both at once.
      clearCounts();
      applyStimulus(0, 1, 0, 2, 4, 3, 0, 1);
      idle(3);
      applyStimulus(0, 1, 0, 1, 2, 6, 0, 1);
      idle(3);
      applyStimulus(0, 0, 1, 0, 10, 1, 0, 1);
      idle(3);
      applyStimulus(0, 1, 1, 3, 0, 0, 0, 1);
      idle(3);
      checkOutput("reject_err_count", 32'(errSeen), 32'd4);

      // LD_time 12:34 on the prescaler's last tick; increment is discarded.
      for (int i = 0; i < TPS && mPresc != TPS - 1; i++) runCycle();
      applyStimulus(0, 1, 0, 1, 2, 3, 4, 1);
      clearCounts();
      idle(TPS - 1);
      checkOutput("post_load_quiet", 32'(tickSeen), 32'd0);
      idle(1);
      checkOutput("post_load_tick", 32'(tickSeen), 32'd1);
      idle(550);
      checkOutput("at_123456", 32'({H_out1, H_out0, M_out1, M_out0, S_out1, S_out0}), 32'h12_3456);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 1);
      checkOutput("reset_no_match", 32'(al_match), 32'd0);

      // Holding LD_time re-loads every cycle.
      applyStimulus(0, 1, 0, 0, 7, 1, 5, 15);
      // Alarm set to current time gives no pulse; a following LD_time does.
      clearCounts();
      applyStimulus(0, 0, 1, 0, 7, 1, 5, 1);
      checkOutput("ld_alarm_no_match", 32'(matchSeen), 32'd0);
      applyStimulus(0, 1, 0, 0, 7, 1, 5, 1);
      checkOutput("ld_time_match", 32'(al_match), 32'd1);

      // Random loads, resets and free running against the reference model.
      for (int i = 0; i < 1500; i++) begin
         int r;
         r = int'($urandom_range(0, 199));
         if (r < 8) applyStimulus(0, 1, 0, $urandom_range(0, 3), $urandom_range(0, 11), $urandom_range(0, 7), $urandom_range(0, 10), 1);
         else if (r < 16) applyStimulus(0, 0, 1, $urandom_range(0, 3), $urandom_range(0, 11), $urandom_range(0, 7), $urandom_range(0, 10), 1);
         else if (r < 20) applyStimulus(0, 1, 1, $urandom_range(0, 3), $urandom_range(0, 11), $urandom_range(0, 7), $urandom_range(0, 10), 1);
         else if (r < 21) applyStimulus(1, 0, 0, 0, 0, 0, 0, 1);
         else runCycle();
      end

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule

// File: doc/aclk_timekeeper.md
Name: aclk_timekeeper

Overview:
- Real-time HH:MM:SS counter for the alarm clock. Runs from the same 10 Hz clk that feeds the alarm-operation stage.
- Holds a programmable alarm time (HH:MM) and drives al_match directly into the alarm-operation stage. That stage qualifies al_match with AL_ON and STOP_al to produce Alarm.
- All time and alarm values are BCD digits.

Parameters:
- TICKS_PER_SEC, 10, clk cycles per real-time second (minimum 2).

Ports:
- clk  input  1  10 Hz system clock; all logic on posedge.
- rst_n  input  1  synchronous, active-low reset.
- LD_time  input  1  load current time from H_in1/H_in0/M_in1/M_in0.
- LD_alarm  input  1  load alarm time from H_in1/H_in0/M_in1/M_in0.
- H_in1  input  2  hour tens digit.
- H_in0  input  4  hour units digit.
- M_in1  input  4  minute tens digit.
- M_in0  input  4  minute units digit.
- H_out1  output  2  current hour tens.
- H_out0  output  4  current hour units.
- M_out1  output  4  current minute tens.
- M_out0  output  4  current minute units.
- S_out1  output  4  current second tens.
- S_out0  output  4  current second units.
- sec_tick  output  1  one-cycle pulse per elapsed second.
- ld_err  output  1  one-cycle pulse when a load is rejected.
- al_match  output  1  one-cycle pulse when time reaches alarm HH:MM:00.

Behaviour:
- Reset (rst_n low at posedge):
  - time = 00:00:00, alarm = 00:00, prescaler = 0.
  - sec_tick, ld_err, al_match = 0.
  - Reset overrides every other input in the same cycle.
- Prescaler:
  - Counts 0..TICKS_PER_SEC-1, then wraps to 0.
  - In the cycle the prescaler holds TICKS_PER_SEC-1, the time increments at that posedge. sec_tick is registered high for the following cycle.
  - After reset, the first increment lands at clock edge TICKS_PER_SEC.
- Increment chain (BCD):
  - S_out0 9->0 carries into S_out1; S_out1 5->0 carries into minutes.
  - M_out0 9->0 carries into M_out1; M_out1 5->0 carries into hours.
  - Hours 23->00. H_out0 wraps 9->0 with a carry only when H_out1 < 2.
  - 23:59:59 -> 00:00:00 in a single edge.
- Input validation, applied to both LD_time and LD_alarm:
  - A load is valid iff H_in0 <= 9, M_in1 <= 5, M_in0 <= 9, and H_in1*10 + H_in0 <= 23.
  - A rejected load leaves the target registers unchanged and pulses ld_err for one cycle, registered.
- LD_time (valid):
  - Hours and minutes take the inputs; seconds = 00; prescaler = 0.
  - Takes priority over an increment falling on the same edge; that increment is discarded.
- LD_alarm (valid):
  - Loads the alarm registers only. Time counting is unaffected.
- LD_time and LD_alarm in the same cycle:
  - Both load the same input value. If the inputs are invalid, both loads are rejected and ld_err pulses once.
- Holding LD_time high:
  - Re-loads every cycle. Time stays at HH:MM:00 and the prescaler stays at 0.
- al_match:
  - Asserted for exactly one cycle, the cycle after an edge at which an increment or a valid LD_time leaves time == alarm HH:MM with seconds 00.
  - No pulse from LD_alarm alone, even if the alarm is set to the current time.
  - No pulse on reset, although 00:00:00 equals the reset alarm.
  - No pulse while time merely stays equal (e.g. prescaler counting inside the matching second).
- Outputs are registers; no combinational path from inputs to outputs.

Test Plan:
- Reset then free-run 25 clk cycles -> sec_tick pulses in the cycles after edges 10 and 20; S_out0 = 1 after edge 10, 2 after edge 20; all other digits 0.
- LD_time 23:59, then 600 clk cycles -> time reads 00:00:00 after edge 600; sec_tick pulsed 60 times; hours wrap with no intermediate 24:xx.
- LD_alarm 00:02, LD_time 00:01, then run -> al_match high for exactly one cycle after the edge where time becomes 00:02:00; stays low for the rest of that second; no second pulse until 24 h later.
- LD_time with H=2,4 / M=3,0 (24:30), and with M_in1 = 6 -> ld_err pulses one cycle; time continues counting unchanged. LD_alarm with H_in0 = 0xA -> ld_err pulses; alarm unchanged.
- LD_time 12:34 asserted on the edge where the prescaler = 9 -> time = 12:34:00, prescaler 0; next sec_tick 10 edges later. Reset mid-count at 12:34:56 -> next cycle 00:00:00, no al_match pulse.
- LD_alarm 07:15 while time = 07:15:00 -> no al_match; then LD_time 07:15 -> al_match pulses in the next cycle.
